// File: rtl/melody_sequencer.sv
// Note-table player: fetches {last, half_period, dur} entries from a 1-cycle ROM and
// renders each as a square wave followed by a fixed silent gap.
module melody_sequencer #(
  parameter int NUM_TRACKS  = 4,
  parameter int IDX_W       = 5,
  parameter int HP_W        = 18,
  parameter int BEAT_CYCLES = 6250000,
  parameter int GAP_CYCLES  = 250000,
  localparam int TRK_W      = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   play,
  input  logic [TRK_W-1:0]       track,
  input  logic                   loop,
  output logic [TRK_W+IDX_W-1:0] rom_addr,
  input  logic [HP_W+4:0]        rom_data,
  output logic                   musica,
  output logic                   busy,
  output logic                   done
);

  // Longest note is 16 units; the down-counter holds at most 16*BEAT_CYCLES-1.
  localparam int DC_W = $clog2(16 * BEAT_CYCLES);
  localparam int GC_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, DONE} state_t;

  state_t            state;
  logic [TRK_W-1:0]  trk_q;
  logic [IDX_W-1:0]  idx_q;
  logic              last_q;
  logic [HP_W-1:0]   hp_q;
  logic [HP_W-1:0]   hc_q;
  logic [DC_W-1:0]   dc_q;
  logic [GC_W-1:0]   gc_q;
  logic              is_last;

  // dur=0 encodes 16 units; result is the PLAY length minus one (down-count terminal 0).
  function automatic logic [DC_W-1:0] play_len_m1(input logic [3:0] dur);
    logic [DC_W-1:0] units;
    units = (dur == 4'd0) ? DC_W'(16) : DC_W'(dur);
    return units * DC_W'(BEAT_CYCLES) - DC_W'(1);
  endfunction

  assign rom_addr = {trk_q, idx_q};
  assign is_last  = last_q || (idx_q == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      trk_q  <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
      hp_q   <= '0;
      hc_q   <= '0;
      dc_q   <= '0;
      gc_q   <= '0;
      musica <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!play) begin
        state  <= IDLE;
        musica <= 1'b0;
        busy   <= 1'b0;
      end else if (state != IDLE && track != trk_q) begin
        trk_q  <= track;
        idx_q  <= '0;
        musica <= 1'b0;
        busy   <= 1'b1;
        state  <= FETCH;
      end else begin
        unique case (state)
          IDLE: begin
            trk_q  <= track;
            idx_q  <= '0;
            musica <= 1'b0;
            busy   <= 1'b1;
            state  <= FETCH;
          end
          FETCH: state <= LOAD;
          LOAD: begin
            last_q <= rom_data[HP_W+4];
            hp_q   <= rom_data[HP_W+3:4];
            dc_q   <= play_len_m1(rom_data[3:0]);
            hc_q   <= '0;
            musica <= 1'b0;
            state  <= PLAY;
          end
          PLAY: begin
            if (dc_q == '0) begin
              musica <= 1'b0;
              gc_q   <= GC_W'(GAP_CYCLES - 1);
              state  <= GAP;
            end else begin
              dc_q <= dc_q - DC_W'(1);
              // half_period of zero is a rest: the tone counter stays parked
              if (hp_q != '0) begin
                if (hc_q == hp_q - HP_W'(1)) begin
                  musica <= ~musica;
                  hc_q   <= '0;
                end else begin
                  hc_q <= hc_q + HP_W'(1);
                end
              end
            end
          end
          GAP: begin
            if (gc_q == '0) begin
              if (is_last) begin
                if (loop) begin
                  idx_q <= '0;
                  state <= FETCH;
                end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
                end
              end else begin
                idx_q <= idx_q + IDX_W'(1);
                state <= FETCH;
              end
            end else begin
              gc_q <= gc_q - GC_W'(1);
            end
          end
          DONE: begin
            musica <= 1'b0;
            busy   <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench: a note-level model expands each played track into per-cycle
// expected {musica, busy, done, rom_addr}; a monitor pops and compares every cycle.
module tb_melody_sequencer;

  localparam int NT = 4;
  localparam int IW = 5;
  localparam int HW = 18;
  localparam int BC = 4;
  localparam int GC = 2;
  localparam int TW = 2;
  localparam int AW = TW + IW;
  localparam int NN = 32;

  typedef struct packed {
    logic          last;
    logic [HW-1:0] hp;
    logic [3:0]    dur;
  } note_t;

  typedef struct packed {
    logic          m;
    logic          b;
    logic          d;
    logic          care;
    logic [AW-1:0] addr;
  } samp_t;

  logic          clk;
  logic          reset;
  logic          play;
  logic [TW-1:0] track;
  logic          loop;
  logic [AW-1:0] rom_addr;
  logic [HW+4:0] rom_data;
  logic          musica;
  logic          busy;
  logic          done;

  note_t         notes   [NT][NN];
  logic [HW+4:0] rom_mem [NT*NN];
  samp_t         exp_q   [$];
  int            vectors;
  int            miscompares;
  int            gen_n;
  int            gen_lim;

  melody_sequencer #(
    .NUM_TRACKS (NT),
    .IDX_W      (IW),
    .HP_W       (HW),
    .BEAT_CYCLES(BC),
    .GAP_CYCLES (GC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .play    (play),
    .track   (track),
    .loop    (loop),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .musica  (musica),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  initial begin
    vectors     = 0;
    miscompares = 0;
  end

  always @(negedge clk) begin
    samp_t s;
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      vectors++;
      if (musica !== s.m || busy !== s.b || done !== s.d || (s.care && rom_addr !== s.addr)) begin
        miscompares++;
        $display("FAIL cycle-sample %0d musica/busy/done/addr: got %b/%b/%b/%h, expected %b/%b/%b/%h (addr checked=%b)",
                 vectors, musica, busy, done, rom_addr, s.m, s.b, s.d, s.addr, s.care);
      end
    end
  end

  task automatic push_s(input logic m, input logic b, input logic d, input logic care,
                        input logic [AW-1:0] a);
    samp_t s;
    if (gen_n < gen_lim) begin
      s.m = m; s.b = b; s.d = d; s.care = care; s.addr = a;
      exp_q.push_back(s);
      gen_n++;
    end
  endtask

  // Expected behaviour of playing track t from note 0, truncated to limit samples.
  task automatic gen_trace(input int t, input bit lp, input int limit);
    int            i;
    int            units;
    bit            fin;
    note_t         nt;
    logic [AW-1:0] a;
    gen_n = 0; gen_lim = limit; i = 0; fin = 1'b0; a = '0;
    while (!fin && gen_n < gen_lim) begin
      nt    = notes[t][i];
      a     = AW'(t * NN + i);
      units = (nt.dur == 4'd0) ? 16 : int'(nt.dur);
      push_s(1'b0, 1'b1, 1'b0, 1'b1, a);
      push_s(1'b0, 1'b1, 1'b0, 1'b1, a);
      for (int k = 0; k < units * BC; k++)
        push_s((nt.hp == '0) ? 1'b0 : (((k / int'(nt.hp)) % 2) == 1), 1'b1, 1'b0, 1'b1, a);
      for (int k = 0; k < GC; k++) push_s(1'b0, 1'b1, 1'b0, 1'b1, a);
      if (nt.last || i == NN - 1) begin
        if (lp) i = 0;
        else    fin = 1'b1;
      end else begin
        i++;
      end
    end
    if (fin) begin
      push_s(1'b0, 1'b0, 1'b1, 1'b1, a);
      push_s(1'b0, 1'b0, 1'b0, 1'b1, a);
      push_s(1'b0, 1'b0, 1'b0, 1'b1, a);
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk); #1;
      c++;
      if (c > 5000) begin
        $display("FAIL drain-timeout: %0d samples pending, expected 0", exp_q.size());
        $fatal(1, "scoreboard stalled");
      end
    end
  endtask

  task automatic start(input int t, input bit lp, input int limit);
    track = TW'(t); loop = lp; play = 1'b1;
    gen_trace(t, lp, limit);
    drain();
  endtask

  task automatic stop();
    play = 1'b0;
    gen_n = 0; gen_lim = 2;
    push_s(1'b0, 1'b0, 1'b0, 1'b0, '0);
    push_s(1'b0, 1'b0, 1'b0, 1'b0, '0);
    drain();
  endtask

  task automatic change(input int t2, input int limit);
    track = TW'(t2);
    gen_trace(t2, loop, limit);
    drain();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    gen_n = 0; gen_lim = 1;
    push_s(1'b0, 1'b0, 1'b0, 1'b1, '0);
    drain();
    reset = 1'b0;
  endtask

  initial begin
    int t, t2, lp, ev;
    for (int tr = 0; tr < NT; tr++)
      for (int i = 0; i < NN; i++) begin
        notes[tr][i].last = 1'b0;
        notes[tr][i].hp   = HW'($urandom_range(0, 5));
        notes[tr][i].dur  = 4'($urandom_range(0, 3));
      end
    notes[0][$urandom_range(1, 5)].last = 1'b1;
    notes[1][0] = '{last: 1'b1, hp: HW'(3), dur: 4'd2};
    notes[2][0] = '{last: 1'b0, hp: HW'(0), dur: 4'd1};
    notes[2][1] = '{last: 1'b1, hp: HW'(2), dur: 4'd1};
    for (int tr = 0; tr < NT; tr++)
      for (int i = 0; i < NN; i++) rom_mem[tr * NN + i] = notes[tr][i];

    reset = 1'b1; play = 1'b0; track = '0; loop = 1'b0;
    gen_n = 0; gen_lim = 2;
    push_s(1'b0, 1'b0, 1'b0, 1'b1, '0);
    push_s(1'b0, 1'b0, 1'b0, 1'b1, '0);
    drain();
    reset = 1'b0;
    gen_n = 0; gen_lim = 2;
    push_s(1'b0, 1'b0, 1'b0, 1'b1, '0);
    push_s(1'b0, 1'b0, 1'b0, 1'b1, '0);
    drain();

    start(1, 1'b0, 100000); stop();           // single note, done pulse
    start(2, 1'b0, 100000); stop();           // rest then tone
    start(2, 1'b1, 40);     stop();           // looping, never done
    start(1, 1'b0, 5); change(2, 100000); stop();  // track switch mid-PLAY
    start(1, 1'b0, 6);      stop();           // play dropped mid-PLAY
    start(2, 1'b0, 7); pulse_reset(); gen_trace(2, 1'b0, 100000); drain(); stop();
    start(3, 1'b0, 100000); stop();           // runs to index 31

    for (int it = 0; it < 25; it++) begin
      t  = int'($urandom_range(0, NT - 1));
      lp = int'($urandom_range(0, 1));
      start(t, lp[0], int'($urandom_range(1, 300)));
      ev = int'($urandom_range(0, 2));
      if (ev == 1) begin
        t2 = (t + int'($urandom_range(1, NT - 1))) % NT;
        change(t2, int'($urandom_range(1, 300)));
      end else if (ev == 2) begin
        pulse_reset();
        gen_trace(t, lp[0], int'($urandom_range(1, 300)));
        drain();
      end
      stop();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL have parameter NUM_TRACKS, default 4: number of selectable melodies.
REQ-002 SHALL have parameter IDX_W, default 5: note-index width, giving 2^IDX_W notes per track.
REQ-003 SHALL have parameter HP_W, default 18: tone half-period width, in clock cycles.
REQ-004 SHALL have parameter BEAT_CYCLES, default 6250000: clock cycles per duration unit.
REQ-005 SHALL have parameter GAP_CYCLES, default 250000: silent cycles inserted after every note.
REQ-006 SHALL have derived parameter TRK_W = clog2(NUM_TRACKS), minimum 1.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port play, input, 1 bit: 1 = play the selected track, 0 = silence.
REQ-010 SHALL have port track, input, TRK_W bits: selected melody (from the game-state decode).
REQ-011 SHALL have port loop, input, 1 bit: 1 = restart the track at note 0 after its last note.
REQ-012 SHALL have port rom_addr, output, TRK_W+IDX_W bits: {latched track, note index}.
REQ-013 SHALL have port rom_data, input, HP_W+5 bits: {last[HP_W+4], half_period[HP_W+3:4], dur[3:0]}. The ROM is synchronous with a fixed read latency of 1 cycle.
REQ-014 SHALL have port musica, output, 1 bit: registered square-wave audio.
REQ-015 SHALL have port busy, output, 1 bit: high in FETCH, LOAD, PLAY and GAP.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse when a non-looping track ends.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, LOAD, PLAY, GAP and DONE.
REQ-018 SHALL, in IDLE with play=1, latch track, set index=0 and go to FETCH next cycle.
REQ-019 SHALL drive rom_addr from registers only; FETCH lasts exactly 1 cycle.
REQ-020 SHALL, in LOAD, capture rom_data into note registers and go to PLAY next cycle.
REQ-021 SHALL interpret dur=0 as 16 units; PLAY lasts dur*BEAT_CYCLES cycles.
REQ-022 SHALL make musica toggle every half_period cycles during PLAY, starting from 0 on PLAY entry.
REQ-023 SHALL treat half_period=0 as a rest: musica held at 0 for the full note duration.
REQ-024 SHALL hold musica at 0 for exactly GAP_CYCLES cycles in GAP.
REQ-025 SHALL, at the end of GAP on a note that is not last, increment the index and go to FETCH.
REQ-026 SHALL treat the note at index 2^IDX_W-1 as last regardless of its flag; the index never wraps silently.
REQ-027 SHALL, at the end of GAP on a last note with loop=1, set index=0 and go to FETCH.
REQ-028 SHALL, at the end of GAP on a last note with loop=0, pulse done for 1 cycle and go to DONE.
REQ-029 SHALL hold musica at 0 in DONE and return to IDLE only when play=0.
REQ-030 SHALL, when play=0 in any state, go to IDLE next cycle with musica=0; this takes effect mid-note.
REQ-031 SHALL, when play=1 and track differs from the latched track in any state other than IDLE, latch the new track, set index=0, go to FETCH and drive musica=0 next cycle.
REQ-032 SHALL apply events with priority: reset > play=0 > track change > normal sequencing.
REQ-033 SHALL make musica and done pure register outputs, with no combinational path from any input.
REQ-034 SHALL size all counters so that dur*BEAT_CYCLES and the half_period count never overflow.

Reset
REQ-035 SHALL, with reset=1 at a clock edge, put the FSM in IDLE and clear musica=0, busy=0, done=0, rom_addr=0 and all counters, from any state.
REQ-036 SHALL restart playback after reset only from IDLE with play=1, at note 0.

Verification
Use BEAT_CYCLES=4, GAP_CYCLES=2 and a ROM model with 1-cycle latency.
REQ-037 Basic note: track 1 note 0 = {last=1, hp=3, dur=2}, play=1 from IDLE -> FETCH shows rom_addr={1,0}; PLAY lasts 8 cycles; musica = 000111 then 00; GAP 2 cycles of 0; done pulses; busy falls.
REQ-038 Rest and sequence: notes {hp=0, dur=1} then {hp=2, dur=1, last=1} -> 4 silent cycles, 2-cycle gap, index 1 fetched, then musica 0011.
REQ-039 Loop: same two-note track with loop=1 -> index returns to 0 after the second GAP; done never asserts; busy stays 1.
REQ-040 Track change mid-note: switch track 1->2 during PLAY -> next cycle musica=0 and state FETCH; following cycle rom_addr={2,0}.
REQ-041 Stop and reset: drop play mid-PLAY -> IDLE next cycle and musica=0; assert reset during GAP -> all outputs 0 next cycle; play held high after reset release -> fresh start at note 0.
REQ-042 Index limit: a track with no last flag -> stops after index 31 with a done pulse.
